// File: rtl/csa_ctrl_pkg.sv
// Shared types and width helpers for the carry-save batch accumulator.
package csa_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

   // Accumulator width: enough headroom for M operands of n bits.
   function automatic int acc_width(input int n, input int m);
      return n + $clog2(m);
   endfunction

   function automatic int cnt_width(input int m);
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/carry_save_adder_stage.sv
// Bitwise 3:2 compressor; cout is unshifted (bit i carries weight 2^(i+1)).
module carry_save_adder_stage #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] c,
   output logic [N-1:0] sum,
   output logic [N-1:0] cout
);

   assign sum  = a ^ b ^ c;
   assign cout = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accum_ctrl.sv
// Batch accumulator: operands fold into a redundant S/C pair, one carry-propagate
// add resolves the batch, and the result is held until the consumer takes it.
module csa_accum_ctrl
   import csa_ctrl_pkg::*;
#(
   parameter  int N  = 8,
   parameter  int M  = 8,
   localparam int W  = acc_width(N, M),
   localparam int CW = cnt_width(M)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_result,
   output logic [CW-1:0] out_count,
   output logic          out_forced
);

   state_t          state, state_nxt;
   logic [W-1:0]    s_q, c_q, res_q;
   logic [W-1:0]    csa_sum, csa_cout, data_ext;
   logic [CW-1:0]   cnt_q, cnt_inc;
   logic            forced_q;
   logic            accept, at_limit;

   assign data_ext = {{(W-N){1'b0}}, in_data};
   assign cnt_inc  = cnt_q + CW'(1);
   assign at_limit = (cnt_inc == CW'(M));

   carry_save_adder_stage #(.N(W)) u_csa (
      .a    (s_q),
      .b    (c_q),
      .c    (data_ext),
      .sum  (csa_sum),
      .cout (csa_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Handshake outputs depend on state alone, never on in_valid/out_ready.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE, ACCUM: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid) state_nxt = (in_last || at_limit) ? RESOLVE : ACCUM;
         end
         RESOLVE: state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q      <= '0;
         c_q      <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
         forced_q <= 1'b0;
      end else if (accept) begin
         s_q   <= csa_sum;
         c_q   <= csa_cout << 1;  // carry MSB falls off: sum is mod 2^W
         cnt_q <= cnt_inc;
         if (at_limit && !in_last) forced_q <= 1'b1;
      end else if (state == RESOLVE) begin
         res_q <= s_q + c_q;
      end else if (state == DONE && out_ready) begin
         s_q      <= '0;
         c_q      <= '0;
         cnt_q    <= '0;
         forced_q <= 1'b0;
      end
   end

   assign out_result = res_q;
   assign out_count  = cnt_q;
   assign out_forced = forced_q;

endmodule

// File: doc/csa_accum_ctrl.md
CSA_ACCUM_CTRL -- requirements
Module: csa_accum_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits.
REQ-002 SHALL have parameter M, default 8, maximum operands per batch (M >= 2).
REQ-003 SHALL derive localparam W = N + $clog2(M), the accumulator and result width.
REQ-004 SHALL have clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have in_valid  input  1  operand beat offered.
REQ-007 SHALL have in_ready  output  1  controller accepts beat.
REQ-008 SHALL have in_data  input  N  unsigned operand.
REQ-009 SHALL have in_last  input  1  final operand of batch.
REQ-010 SHALL have out_valid  output  1  result available.
REQ-011 SHALL have out_ready  input  1  consumer takes result.
REQ-012 SHALL have out_result  output  W  batch sum, mod 2^W.
REQ-013 SHALL have out_count  output  $clog2(M)+1  operands in batch.
REQ-014 SHALL have out_forced  output  1  batch closed at M beats without in_last.

Function
REQ-015 SHALL accept a beat only when in_valid && in_ready in the same cycle; in_valid low SHALL leave all state unchanged.
REQ-016 SHALL keep the running sum in redundant form: registers S[W-1:0] and C[W-1:0], with C stored pre-shifted to weight.
REQ-017 SHALL, on each accepted beat, compute (sum, cout) = CSA(S, C, zero-extended in_data), then set S <= sum and C <= {cout[W-2:0], 1'b0}, all in one cycle.
REQ-018 SHALL implement states IDLE, ACCUM, RESOLVE and DONE.
REQ-019 IDLE: in_ready=1 and S=C=count=0; an accepted beat SHALL go to RESOLVE if in_last is high, otherwise to ACCUM.
REQ-020 ACCUM: in_ready=1; an accepted beat with in_last SHALL go to RESOLVE.
REQ-021 ACCUM: the M-th accepted beat SHALL go to RESOLVE regardless of in_last, setting out_forced=1 if in_last was low.
REQ-022 RESOLVE: in_ready=0; the result register SHALL load S + C (mod 2^W) and the state SHALL go to DONE.
REQ-023 DONE: out_valid=1 and in_ready=0; out_result, out_count and out_forced SHALL hold stable until out_valid && out_ready.
REQ-024 On the DONE handshake, S, C, count and out_forced SHALL clear and the state SHALL go to IDLE; in_ready SHALL be high the following cycle.
REQ-025 Latency SHALL be fixed: if the last beat is accepted in cycle t, out_valid rises in cycle t+2.
REQ-026 in_ready and out_valid SHALL be decoded from registered state only, with no combinational path from in_valid or out_ready.

Reset
REQ-027 rst SHALL force IDLE and clear S, C, count, the result register and out_forced on the next edge, from any state.
REQ-028 During and after reset, outputs SHALL be: in_ready=1 (once out of reset), out_valid=0, out_result=0, out_count=0, out_forced=0.
REQ-029 A batch in progress at reset SHALL be discarded with no output produced.

Structure
REQ-030 Package csa_ctrl_pkg SHALL hold the state enum typedef (IDLE, ACCUM, RESOLVE, DONE) and the W/count-width helper functions.
REQ-031 SHALL instantiate exactly one carry_save_adder_stage with N=W as the sole 3:2 compressor.
REQ-032 The final S+C add SHALL be a single behavioural adder.

Verification (N=8, M=8, W=11)
REQ-033 Beats 10, 20, 30 with last on 30 -> out_result=60, out_count=3, out_forced=0, out_valid rises 2 cycles after the last beat.
REQ-034 Single beat 255 with last -> out_result=255, out_count=1.
REQ-035 Eight beats of 255, in_last never asserted -> out_result=2040, out_count=8, out_forced=1, ninth beat not accepted (in_ready=0).
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle and in_ready=1.
REQ-037 Beats 7, 9, then rst for 1 cycle, then beat 5 with last -> out_result=5, out_count=1.
REQ-038 Beats 1, 2, 3 with random in_valid bubbles -> out_result=6, out_count=3; S and C unchanged on bubble cycles.
